// File: rtl/mouse_pkg.sv
// mouse_pkg -- shared constants for the mouse input conditioning block.
//   Default position width and clamp limits, plus the button channel index map
//   (left/right/middle) so callers never hard-code bit positions.
package mouse_pkg;

  localparam int POS_W_DEF   = 12;
  localparam int X_MAX_DEF   = 1023;
  localparam int Y_MAX_DEF   = 767;
  localparam int BTN_N_DEF   = 3;

  localparam int BTN_LEFT    = 0;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_MIDDLE  = 2;

endpackage

// File: rtl/mouse_sync_btn_debounce.sv
// btn_debounce -- one button channel: synchronizer chain, optional debounce
// filter, registered press/release pulses.
//   Build option: define MOUSE_SYNC_DEBOUNCE_EN to enable the debounce counter.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     btn_in        raw asynchronous button level
//     btn_out       conditioned level
//     btn_press     one-cycle pulse in the first cycle btn_out shows 1
//     btn_release   one-cycle pulse in the first cycle btn_out shows 0
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_press,
  output logic btn_release
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_out;
  logic                   r_press;
  logic                   r_release;
  logic                   w_lvl;
  logic                   w_next;

  // Plain flop chain: nothing between stages so each stage gets a full cycle
  // to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
  end

  assign w_lvl = r_sync[SYNC_STAGES-1];

`ifdef MOUSE_SYNC_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Count cycles the synchronized level disagrees with the output; any agreeing
  // cycle restarts the count, so short pulses never reach the terminal value.
  always_comb begin
    w_next    = r_out;
    w_cnt_nxt = '0;
    if (w_lvl != r_out) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) w_next    = w_lvl;
      else                                      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nxt;
  end
`else
  // No filtering: output is the last sync stage delayed one register.
  always_comb begin
    w_next = w_lvl;
  end
`endif

  // Pulses are derived from the next output value so they line up with the
  // first cycle btn_out carries the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_out     <= w_next;
      r_press   <= w_next & ~r_out;
      r_release <= ~w_next & r_out;
    end
  end

  assign btn_out     = r_out;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/mouse_sync.sv
// mouse_sync -- registers and clamps mouse position updates and conditions the
// button inputs (synchronize, optional debounce, press/release pulses).
//   Build option: define MOUSE_SYNC_DEBOUNCE_EN to enable button debouncing.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     x_pos_in, y_pos_in       raw coordinates, sampled when pos_valid_in=1
//     pos_valid_in             one-cycle update strobe
//     btn_in                   raw asynchronous button levels
//     x_pos_out, y_pos_out     clamped coordinates, held between updates
//     pos_valid_out            strobe one cycle after pos_valid_in
//     btn_out                  conditioned button levels
//     btn_press, btn_release   per-channel edge pulses on btn_out
module mouse_sync
  import mouse_pkg::*;
#(
  parameter int POS_W           = POS_W_DEF,
  parameter int BTN_N           = BTN_N_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int X_MAX           = X_MAX_DEF,
  parameter int Y_MAX           = Y_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] x_pos_in,
  input  logic [POS_W-1:0] y_pos_in,
  input  logic             pos_valid_in,
  input  logic [BTN_N-1:0] btn_in,
  output logic [POS_W-1:0] x_pos_out,
  output logic [POS_W-1:0] y_pos_out,
  output logic             pos_valid_out,
  output logic [BTN_N-1:0] btn_out,
  output logic [BTN_N-1:0] btn_press,
  output logic [BTN_N-1:0] btn_release
);

  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);

  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic             r_vld;
  logic [POS_W-1:0] w_x_clamp;
  logic [POS_W-1:0] w_y_clamp;

  // Unsigned saturate at the limit; values at the limit pass unchanged.
  assign w_x_clamp = (x_pos_in > X_LIM) ? X_LIM : x_pos_in;
  assign w_y_clamp = (y_pos_in > Y_LIM) ? Y_LIM : y_pos_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= pos_valid_in;
      if (pos_valid_in) begin
        r_x <= w_x_clamp;
        r_y <= w_y_clamp;
      end
    end
  end

  assign x_pos_out     = r_x;
  assign y_pos_out     = r_y;
  assign pos_valid_out = r_vld;

  for (genvar g = 0; g < BTN_N; g++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[g]),
      .btn_out     (btn_out[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
    );
  end

endmodule

// File: doc/mouse_sync.md
MOUSE_SYNC -- requirements
Module: mouse_sync

Interface
REQ-001 Parameter POS_W, default 12, width in bits of each position coordinate.
REQ-002 Parameter BTN_N, default 3, number of button channels (index 0 left, 1 right, 2 middle).
REQ-003 Parameter SYNC_STAGES, default 2, flop depth of each button synchronizer chain, legal range 2..4.
REQ-004 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a debounced button changes, legal range >= 1.
REQ-005 Parameter X_MAX, default 1023, upper clamp for the x coordinate.
REQ-006 Parameter Y_MAX, default 767, upper clamp for the y coordinate.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 x_pos_in  input  POS_W  raw x coordinate.
REQ-010 y_pos_in  input  POS_W  raw y coordinate.
REQ-011 pos_valid_in  input  1  one-cycle strobe; x/y inputs valid this cycle.
REQ-012 btn_in  input  BTN_N  raw asynchronous button levels.
REQ-013 x_pos_out  output  POS_W  registered, clamped x.
REQ-014 y_pos_out  output  POS_W  registered, clamped y.
REQ-015 pos_valid_out  output  1  one-cycle strobe marking a position update.
REQ-016 btn_out  output  BTN_N  synchronized (and debounced when enabled) button levels.
REQ-017 btn_press  output  BTN_N  one-cycle pulse per channel on btn_out 0->1.
REQ-018 btn_release  output  BTN_N  one-cycle pulse per channel on btn_out 1->0.

Function
REQ-019 On pos_valid_in=1 at edge t, x/y_pos_out shall take clamped inputs and pos_valid_out shall be 1 in cycle t+1 only; latency exactly 1 cycle.
REQ-020 With pos_valid_in=0, x/y_pos_out shall hold their last value and pos_valid_out shall be 0.
REQ-021 Clamp: x_pos_out = min(x_pos_in, X_MAX), y_pos_out = min(y_pos_in, Y_MAX), unsigned compare, no wrap; values equal to the max pass unchanged.
REQ-022 Back-to-back pos_valid_in strobes shall each produce an update; pos_valid_out stays high for consecutive cycles.
REQ-023 Each btn_in bit shall pass through its own SYNC_STAGES-flop chain; no logic between chain flops.
REQ-024 btn_press[i]/btn_release[i] shall be registered and asserted in the first cycle btn_out[i] shows the new level; never both high; channels independent.
REQ-025 Simultaneous changes on several channels shall each produce their own pulses in the same cycle.

Reset
REQ-026 While rst=1: x_pos_out, y_pos_out, pos_valid_out, btn_out, btn_press, btn_release, all synchronizer flops and debounce counters shall be 0 on the next edge.
REQ-027 Reset asserted mid-debounce shall discard the pending count; after release a button held high yields btn_press after full latency again.
REQ-028 A button held high through reset deassertion shall produce exactly one btn_press.

Configuration
REQ-029 Macro MOUSE_SYNC_DEBOUNCE_EN defined: per channel, counter increments each cycle synchronized level != btn_out[i], clears to 0 when equal; when counter reaches DEBOUNCE_CYCLES-1 with level still differing, btn_out[i] flips next edge and counter clears; latency input->btn_out = SYNC_STAGES+DEBOUNCE_CYCLES cycles; pulses shorter than DEBOUNCE_CYCLES ignored.
REQ-030 Counter width shall be $clog2(DEBOUNCE_CYCLES+1), saturating never needed by construction.
REQ-031 Macro undefined: no counters; btn_out[i] shall equal last synchronizer stage delayed one register; latency SYNC_STAGES+1 cycles; DEBOUNCE_CYCLES ignored.

Structure
REQ-032 Package mouse_pkg shall hold POS_W default, X_MAX/Y_MAX defaults, BTN_LEFT=0, BTN_RIGHT=1, BTN_MIDDLE=2 index constants.
REQ-033 Sub-module btn_debounce shall implement one channel (synchronizer, optional debounce, edge pulses), instantiated BTN_N times via generate.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, X_MAX=1023, Y_MAX=767)
REQ-034 pos_valid_in pulse with x=500,y=300 -> next cycle x_pos_out=500, y_pos_out=300, pos_valid_out=1 one cycle; outputs hold afterward.
REQ-035 x=2000,y=767 -> x_pos_out=1023, y_pos_out=767; x=4095,y=4095 -> 1023/767.
REQ-036 Debounce on: btn_in[0] rises and holds -> btn_out[0]=1 and btn_press[0]=1 exactly 6 cycles later, btn_press one cycle wide; fall -> btn_release[0] after 6 cycles.
REQ-037 Debounce on: btn_in[1] high for 3 cycles then low -> btn_out[1] stays 0, no pulses; debounce off: same stimulus -> btn_out[1] high 3 cycles, press and release each once.
REQ-038 rst asserted 2 cycles into a held press, released -> all outputs 0 during reset, single btn_press 6 cycles after rst release.
REQ-039 btn_in 3'b111 rises in one cycle -> btn_press=3'b111 in one common cycle.
